// File: rtl/bootram_seq.sv
// rtl/bootram_seq.sv - PicoRV32 32-bit bus to 2Kx8 boot BSRAM byte-lane sequencer.
// Optional byte-wide loader port: define BOOTRAM_SEQ_LOADER_EN.
module bootram_seq #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_rdata,
    output logic              ram_ce,
    output logic              ram_oce,
    output logic              ram_wre,
    output logic [ADDR_W-1:0] ram_ad,
    output logic [7:0]        ram_din,
    input  logic [7:0]        ram_dout
`ifdef BOOTRAM_SEQ_LOADER_EN
    ,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              ld_ready
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_RCAP, S_WRITE, S_DONE, S_LDW
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [1:0]         r_cnt;
    logic [ADDR_W-3:0]  r_word;
    logic [31:0]        r_wdata;
    logic [3:0]         r_wstrb;
    logic [31:0]        r_rdata;

    logic               w_ce;
    logic               w_wre;
    logic               w_ready;
    logic [ADDR_W-1:0]  w_ad;
    logic [7:0]         w_din;
    logic [1:0]         w_lane;
    logic               w_unused_addr;

    assign w_unused_addr = ^{mem_addr[31:ADDR_W], mem_addr[1:0]};
    // Read data for lane cnt-1 arrives one edge after its address was clocked.
    assign w_lane = r_cnt - 2'd1;

`ifdef BOOTRAM_SEQ_LOADER_EN
    logic w_ld_ready;
`endif

    always_comb begin
        w_next  = r_state;
        w_ce    = 1'b0;
        w_wre   = 1'b0;
        w_ready = 1'b0;
        w_ad    = {r_word, r_cnt};
        w_din   = r_wdata[{r_cnt, 3'b000} +: 8];
`ifdef BOOTRAM_SEQ_LOADER_EN
        w_ld_ready = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
`ifdef BOOTRAM_SEQ_LOADER_EN
                if (ld_valid)
                    w_next = S_LDW;
                else
`endif
                if (mem_valid)
                    w_next = (mem_wstrb != 4'd0) ? S_WRITE : S_READ;
            end
            S_READ: begin
                w_ce = 1'b1;
                if (r_cnt == 2'd3)
                    w_next = S_RCAP;
            end
            S_RCAP:  w_next = S_DONE;
            S_WRITE: begin
                // Unstrobed lanes still take a cycle so write timing is fixed.
                w_ce  = r_wstrb[r_cnt];
                w_wre = r_wstrb[r_cnt];
                if (r_cnt == 2'd3)
                    w_next = S_DONE;
            end
            S_DONE: begin
                w_ready = 1'b1;
                w_next  = S_IDLE;
            end
`ifdef BOOTRAM_SEQ_LOADER_EN
            S_LDW: begin
                w_ce       = 1'b1;
                w_wre      = 1'b1;
                w_ad       = ld_addr;
                w_din      = ld_data;
                w_ld_ready = 1'b1;
                w_next     = S_IDLE;
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 2'd0;
            r_word  <= '0;
            r_wdata <= 32'd0;
            r_wstrb <= 4'd0;
            r_rdata <= 32'd0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= 2'd0;
                    if (w_next == S_READ || w_next == S_WRITE) begin
                        r_word  <= mem_addr[ADDR_W-1:2];
                        r_wdata <= mem_wdata;
                        r_wstrb <= mem_wstrb;
                    end
                end
                S_READ: begin
                    r_cnt <= r_cnt + 2'd1;
                    if (r_cnt != 2'd0)
                        r_rdata[{w_lane, 3'b000} +: 8] <= ram_dout;
                end
                S_RCAP:  r_rdata[31:24] <= ram_dout;
                S_WRITE: r_cnt <= r_cnt + 2'd1;
                default: r_cnt <= 2'd0;
            endcase
        end
    end

    // Gating with reset stops any lane write in the cycle reset is asserted.
    assign ram_ce    = w_ce & ~reset;
    assign ram_wre   = w_wre & ~reset;
    assign ram_oce   = 1'b1;
    assign ram_ad    = reset ? '0 : w_ad;
    assign ram_din   = reset ? 8'd0 : w_din;
    assign mem_ready = w_ready & ~reset;
    assign mem_rdata = r_rdata;
`ifdef BOOTRAM_SEQ_LOADER_EN
    assign ld_ready  = w_ld_ready & ~reset;
`endif

endmodule

// File: tb/tb_bootram_seq.sv
// tb/tb_bootram_seq.sv - scoreboard bench for bootram_seq with a behavioural 2Kx8 BSRAM.
module tb_bootram_seq;

    localparam int ADDR_W = 11;

    logic              clk = 1'b0;
    logic              reset;
    logic              mem_valid;
    logic              mem_ready;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic [31:0]       mem_rdata;
    logic              ram_ce;
    logic              ram_oce;
    logic              ram_wre;
    logic [ADDR_W-1:0] ram_ad;
    logic [7:0]        ram_din;
    logic [7:0]        ram_dout = 8'd0;
`ifdef BOOTRAM_SEQ_LOADER_EN
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [7:0]        ld_data;
    logic              ld_ready;
`endif

    bootram_seq #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .ram_ce    (ram_ce),
        .ram_oce   (ram_oce),
        .ram_wre   (ram_wre),
        .ram_ad    (ram_ad),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
`ifdef BOOTRAM_SEQ_LOADER_EN
        ,
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready)
`endif
    );

    always #5 clk = ~clk;

    // Single-port RAM, bypass mode: a write also drives its data to dout.
    logic [7:0] ram [0:2047];
    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_wre) begin
                ram[ram_ad] = ram_din;
                ram_dout <= ram_din;
            end else begin
                ram_dout <= ram[ram_ad];
            end
        end
    end

    int wre_cnt = 0;
    int ready_cnt = 0;
    int ldr_cnt = 0;
    int rd_n = 0;
    logic [ADDR_W-1:0] rd_first = '0;
    logic [ADDR_W-1:0] rd_last = '0;
    always @(negedge clk) begin
        if (ram_ce && ram_wre) wre_cnt++;
        if (mem_ready) ready_cnt++;
        if (ram_ce && !ram_wre) begin
            if (rd_n == 0) rd_first = ram_ad;
            rd_last = ram_ad;
            rd_n++;
        end
`ifdef BOOTRAM_SEQ_LOADER_EN
        if (ld_ready) ldr_cnt++;
`endif
    end

    typedef struct {
        logic [31:0] rdata;
        int          lat;
    } exp_t;
    exp_t sb[$];

    int n_tests = 0;
    int n_fail = 0;
    logic [31:0] model_rd = 32'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Waits for mem_ready counting edges from the first one after stimulus, then scores it.
    task automatic wait_ready(input string tag);
        int   edges;
        bit   seen;
        exp_t e;
        edges = 0;
        seen  = 0;
        while (edges < 40 && !seen) begin
            @(posedge clk);
            edges++;
            #1;
            if (edges == 1) begin
                mem_addr  = 32'hDEAD_BEEF;
                mem_wdata = 32'h5A5A_5A5A;
                mem_wstrb = 4'hA;
            end
            if (mem_ready) seen = 1;
        end
        mem_valid = 1'b0;
        e = sb.pop_front();
        if (!seen) begin
            check({tag, " timeout"}, 32'd0, 32'd1);
        end else begin
            check({tag, " rdata"}, mem_rdata, e.rdata);
            check({tag, " latency"}, edges - 1, e.lat);
            @(posedge clk);
            #1;
            check({tag, " ready one cycle"}, {31'd0, mem_ready}, 32'd0);
        end
    endtask

    task automatic bus_access(input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] strb, input logic [31:0] exp_rd,
                              input string tag);
        exp_t e;
        if (strb == 4'd0) model_rd = exp_rd;
        e.rdata = model_rd;
        e.lat   = (strb == 4'd0) ? 5 : 4;
        sb.push_back(e);
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = strb;
        wait_ready(tag);
    endtask

    initial begin
        reset     = 1'b1;
        mem_valid = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_wstrb = 4'd0;
`ifdef BOOTRAM_SEQ_LOADER_EN
        ld_valid  = 1'b0;
        ld_addr   = '0;
        ld_data   = 8'd0;
`endif
        for (int i = 0; i < 2048; i++) ram[i] = 8'h00;
        ram[16] = 8'h13; ram[17] = 8'h37; ram[18] = 8'hBE; ram[19] = 8'hEF;
        for (int i = 32; i < 36; i++) ram[i] = 8'hFF;
        for (int i = 64; i < 68; i++) ram[i] = 8'hFF;

        repeat (2) @(posedge clk);
        #1;
        check("reset mem_ready", {31'd0, mem_ready}, 32'd0);
        check("reset mem_rdata", mem_rdata, 32'd0);
        check("reset ram_ce", {31'd0, ram_ce}, 32'd0);
        check("reset ram_wre", {31'd0, ram_wre}, 32'd0);
        check("reset ram_ad", {21'd0, ram_ad}, 32'd0);
        check("ram_oce", {31'd0, ram_oce}, 32'd1);
        @(negedge clk);
        reset = 1'b0;

        bus_access(32'h10, 32'd0, 4'h0, 32'hEFBE3713, "rd 0x10");

        wre_cnt = 0;
        bus_access(32'h7FC, 32'hA1B2C3D4, 4'hF, 32'd0, "wr 0x7fc");
        check("wr 0x7fc pulses", wre_cnt, 4);
        check("wr 0x7fc bytes", {ram[2047], ram[2046], ram[2045], ram[2044]}, 32'hA1B2C3D4);
        check("no wrap byte 0", {24'd0, ram[0]}, 32'd0);
        bus_access(32'h7FC, 32'd0, 4'h0, 32'hA1B2C3D4, "rd 0x7fc");

        wre_cnt = 0;
        bus_access(32'h20, 32'h11223344, 4'h5, 32'd0, "wr strb5");
        check("wr strb5 pulses", wre_cnt, 2);
        bus_access(32'h20, 32'd0, 4'h0, 32'hFF22FF44, "rd strb5");

        rd_n = 0;
        bus_access(32'hFFFF_F812, 32'd0, 4'h0, 32'hEFBE3713, "rd alias");
        check("alias first addr", {21'd0, rd_first}, 32'h10);
        check("alias last addr", {21'd0, rd_last}, 32'h13);
        check("alias read count", rd_n, 4);

        // Reset lands in the WRITE cnt=1 cycle: only lane 0 may be written.
        wre_cnt = 0;
        ready_cnt = 0;
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = 32'h40;
        mem_wdata = 32'h55667788;
        mem_wstrb = 4'hF;
        @(negedge clk);
        @(negedge clk);
        reset     = 1'b1;
        mem_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rst ram_ce after edge", {31'd0, ram_ce}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("rst no ready", ready_cnt, 0);
        check("rst lane writes", wre_cnt, 1);
        check("rst bytes", {ram[67], ram[66], ram[65], ram[64]}, 32'hFFFFFF88);
        bus_access(32'h40, 32'd0, 4'h0, 32'hFFFFFF88, "rd after rst");

`ifdef BOOTRAM_SEQ_LOADER_EN
        begin
            exp_t e;
            ldr_cnt = 0;
            model_rd = 32'h5ABE3713;
            e.rdata = model_rd;
            e.lat   = 7;
            sb.push_back(e);
            @(negedge clk);
            ld_valid  = 1'b1;
            ld_addr   = 11'h013;
            ld_data   = 8'h5A;
            mem_valid = 1'b1;
            mem_addr  = 32'h10;
            mem_wstrb = 4'h0;
            @(negedge clk);
            check("ldw ld_ready", {31'd0, ld_ready}, 32'd1);
            check("ldw ram_wre", {31'd0, ram_wre}, 32'd1);
            check("ldw ram_ad", {21'd0, ram_ad}, 32'h13);
            ld_valid = 1'b0;
            // The first edge already passed; resume the scored wait from edge 1.
            begin
                int   edges;
                bit   seen;
                edges = 1;
                seen  = 0;
                while (edges < 40 && !seen) begin
                    @(posedge clk);
                    edges++;
                    #1;
                    if (mem_ready) seen = 1;
                end
                mem_valid = 1'b0;
                e = sb.pop_front();
                if (!seen) begin
                    check("ld rd timeout", 32'd0, 32'd1);
                end else begin
                    check("ld rd rdata", mem_rdata, e.rdata);
                    check("ld rd latency", edges - 1, e.lat);
                end
            end
            check("ld_ready pulses", ldr_cnt, 1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bootram_seq.md
Name: bootram_seq

Overview:
- Sequencer that lets the PicoRV32 native 32-bit memory bus read and write the single-port 2Kx8 boot BSRAM (SP primitive, bypass read mode, 1-cycle read latency).
- Each word access is split into four byte-lane accesses, byte 0 first.
- Sits between the SoC bus decoder and the 8-bit bootram macro.
- Optionally arbitrates a byte-wide loader port for programming the RAM.

Parameters:
- ADDR_W, 11, RAM byte address width; word index is mem_addr[ADDR_W-1:2].

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- mem_valid  in  1  bus request.
- mem_ready  out  1  one-cycle completion pulse.
- mem_addr  in  32  byte address; only [ADDR_W-1:2] used.
- mem_wdata  in  32  write data; lane k = bits [8k+7:8k].
- mem_wstrb  in  4  byte strobes; 0 = read.
- mem_rdata  out  32  read data.
- ram_ce  out  1  RAM clock enable.
- ram_oce  out  1  RAM output enable; constant 1.
- ram_wre  out  1  RAM write enable.
- ram_ad  out  ADDR_W  RAM byte address.
- ram_din  out  8  RAM write data.
- ram_dout  in  8  RAM read data, valid one edge after address is clocked with ram_ce=1, ram_wre=0.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE, cnt=0, mem_ready=0, mem_rdata=0, ram_ce=0, ram_wre=0. ram_ad and ram_din are don't-care but driven 0.
- RAM outputs are combinational from state/cnt: ram_ad={word,cnt}, ram_din=wdata lane cnt.
- Request latch: at acceptance, word, wdata and wstrb are latched. The master may change them afterwards without effect.
- States: IDLE, READ, RCAP, WRITE, DONE (plus LDW under the option).
- IDLE:
  - mem_valid=1 and wstrb==0 -> READ, cnt=0.
  - mem_valid=1 and wstrb!=0 -> WRITE, cnt=0.
  - ram_ce=0.
- READ:
  - ram_ce=1, ram_wre=0.
  - cnt increments each cycle. At each edge with cnt>=1, ram_dout is stored into mem_rdata lane cnt-1.
  - cnt==3 -> RCAP.
- RCAP: ram_ce=0. At the edge, ram_dout is stored into lane 3; -> DONE.
- WRITE:
  - ram_ce=ram_wre=mem_wstrb_latched[cnt].
  - Unstrobed lanes are idle cycles, so timing is fixed.
  - cnt==3 -> DONE.
- DONE: mem_ready=1 for exactly one cycle; -> IDLE. No request is accepted in DONE.
- Latency, edge 0 = the edge that samples mem_valid in IDLE:
  - Read: mem_ready high in the cycle after edge 5.
  - Write: mem_ready high in the cycle after edge 4.
- mem_rdata:
  - Valid while mem_ready=1 on reads; held until the next read overwrites it.
  - Writes leave it unchanged.
  - Partial updates are visible during READ; the master must only sample on mem_ready.
- Back-to-back: the earliest new acceptance is the edge ending the DONE cycle's successor IDLE cycle. The master drops mem_valid after seeing mem_ready.
- Address aliasing: mem_addr bits above ADDR_W-1 and bits [1:0] are ignored. Word index 2^(ADDR_W-2)-1 accesses bytes 2044..2047 with no wrap into byte 0.
- Reset mid-transaction: next state IDLE, ram_ce=0 immediately after the edge, no further lane writes, mem_ready=0. Partially written words remain partially written.
- A simultaneous reset and mem_valid is not accepted.

Optional Feature:
- Macro: BOOTRAM_SEQ_LOADER_EN.
- Defined: adds these ports:
  - ld_valid  in  1
  - ld_addr  in  ADDR_W
  - ld_data  in  8
  - ld_ready  out  1
- Arbitration: in IDLE, ld_valid has priority over mem_valid. If both are high, the loader wins and the bus request waits.
- LDW state (one cycle): ram_ce=ram_wre=1, ram_ad=ld_addr, ram_din=ld_data, ld_ready=1; -> IDLE.
- ld_ready reset value is 0. A loader request in flight is never preempted.
- Not defined: loader ports and the LDW state are absent; behaviour is exactly as above.

Test Plan:
- Preload bytes 0x10..0x13 = 13,37,BE,EF; read mem_addr=0x10 -> mem_ready exactly one cycle, 5 edges after acceptance; mem_rdata=0xEFBE3713.
- Write mem_addr=0x7FC, wdata=0xA1B2C3D4, wstrb=0xF -> ready after 4 edges; RAM bytes 0x7FC..0x7FF = D4,C3,B2,A1; readback gives 0xA1B2C3D4.
- Write wstrb=0x5, wdata=0x11223344 to a word holding 0xFFFFFFFF -> exactly 2 ram_wre pulses (lanes 0 and 2); readback 0xFF22FF44.
- mem_addr=0xFFFF_F812 read -> accesses RAM bytes 0x010..0x013 (aliasing, low bits ignored).
- Assert reset during WRITE cnt=1 with wstrb=0xF -> only lane 0 written, mem_ready never pulses, ram_ce=0 the next cycle, state IDLE.
- With BOOTRAM_SEQ_LOADER_EN: ld_valid and mem_valid asserted in the same cycle -> LDW first with ld_ready one cycle; the bus read then completes with correct data, including the just-loaded byte.
